// File: rtl/mem_port_pkg.sv
//==============================================================================
// mem_port_pkg : shared types and opcodes for the memory port arbiter.
// Revision     : 1.0
//==============================================================================
`default_nettype none

package mem_port_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } arb_state_t;

  localparam logic MEM_OP_RD = 1'b0;
  localparam logic MEM_OP_WR = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_port_rr2.sv
//==============================================================================
// mem_port_rr2 : two-way combinational grant; MEM_PORT_ARBITER_FIXED_PRIO_EN
//                makes client 0 always win ties.
// Revision     : 1.0
//==============================================================================
`default_nettype none

module mem_port_rr2 (
  input  logic valid0,
  input  logic valid1,
  input  logic prio,
  output logic sel,
  output logic any
);

  assign any = valid0 | valid1;

`ifdef MEM_PORT_ARBITER_FIXED_PRIO_EN
  logic unused_prio;
  assign unused_prio = prio;
  assign sel         = ~valid0 & valid1;
`else
  // A tie goes to the client currently holding priority.
  assign sel = (valid0 & valid1) ? prio : valid1;
`endif

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//==============================================================================
// mem_port_arbiter : shares one memory req/wr/rd port between two clients,
//                    granting whole transactions. Option: MEM_PORT_ARBITER_FIXED_PRIO_EN.
// Revision         : 1.0
//==============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_port_pkg::*;
#(
  parameter int MEM_LEN_BITS  = 8,
  parameter int MEM_ADDR_BITS = 64,
  parameter int MEM_DATA_BITS = 64
) (
  input  logic                     clock,
  input  logic                     reset,

  input  logic                     c0_req_valid,
  input  logic                     c0_req_opcode,
  input  logic [MEM_LEN_BITS-1:0]  c0_req_len,
  input  logic [MEM_ADDR_BITS-1:0] c0_req_addr,
  output logic                     c0_req_ready,
  input  logic                     c0_wr_valid,
  input  logic [MEM_DATA_BITS-1:0] c0_wr_bits,
  output logic                     c0_rd_valid,
  output logic [MEM_DATA_BITS-1:0] c0_rd_bits,
  input  logic                     c0_rd_ready,

  input  logic                     c1_req_valid,
  input  logic                     c1_req_opcode,
  input  logic [MEM_LEN_BITS-1:0]  c1_req_len,
  input  logic [MEM_ADDR_BITS-1:0] c1_req_addr,
  output logic                     c1_req_ready,
  input  logic                     c1_wr_valid,
  input  logic [MEM_DATA_BITS-1:0] c1_wr_bits,
  output logic                     c1_rd_valid,
  output logic [MEM_DATA_BITS-1:0] c1_rd_bits,
  input  logic                     c1_rd_ready,

  output logic                     mem_req_valid,
  output logic                     mem_req_opcode,
  output logic [MEM_LEN_BITS-1:0]  mem_req_len,
  output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
  output logic                     mem_wr_valid,
  output logic [MEM_DATA_BITS-1:0] mem_wr_bits,
  input  logic                     mem_rd_valid,
  input  logic [MEM_DATA_BITS-1:0] mem_rd_bits,
  output logic                     mem_rd_ready,
  output logic                     busy
);

  arb_state_t              state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    prio_q,  prio_d;
  logic [MEM_LEN_BITS-1:0] cnt_q,   cnt_d;

  logic arb_sel;
  logic arb_any;
  logic beat_fire;

  mem_port_rr2 u_rr2 (
    .valid0 (c0_req_valid),
    .valid1 (c1_req_valid),
    .prio   (prio_q),
    .sel    (arb_sel),
    .any    (arb_any)
  );

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    prio_d         = prio_q;
    cnt_d          = cnt_q;
    beat_fire      = 1'b0;
    c0_req_ready   = 1'b0;
    c1_req_ready   = 1'b0;
    c0_rd_valid    = 1'b0;
    c0_rd_bits     = '0;
    c1_rd_valid    = 1'b0;
    c1_rd_bits     = '0;
    mem_req_valid  = 1'b0;
    mem_req_opcode = 1'b0;
    mem_req_len    = '0;
    mem_req_addr   = '0;
    mem_wr_valid   = 1'b0;
    mem_wr_bits    = '0;
    mem_rd_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        // Gated by reset so every output reads zero while reset is held.
        if (arb_any && reset) begin
          mem_req_valid  = 1'b1;
          mem_req_opcode = arb_sel ? c1_req_opcode : c0_req_opcode;
          mem_req_len    = arb_sel ? c1_req_len    : c0_req_len;
          mem_req_addr   = arb_sel ? c1_req_addr   : c0_req_addr;
          c0_req_ready   = ~arb_sel;
          c1_req_ready   = arb_sel;
          owner_d        = arb_sel;
          cnt_d          = mem_req_len;
          state_d        = (mem_req_opcode == MEM_OP_WR) ? WR : RD;
        end
      end
      RD: begin
        mem_rd_ready = owner_q ? c1_rd_ready : c0_rd_ready;
        if (owner_q) begin
          c1_rd_valid = mem_rd_valid;
          c1_rd_bits  = mem_rd_bits;
        end else begin
          c0_rd_valid = mem_rd_valid;
          c0_rd_bits  = mem_rd_bits;
        end
        beat_fire = mem_rd_valid & mem_rd_ready;
      end
      WR: begin
        mem_wr_valid = owner_q ? c1_wr_valid : c0_wr_valid;
        mem_wr_bits  = owner_q ? c1_wr_bits  : c0_wr_bits;
        beat_fire    = mem_wr_valid;
      end
      default: state_d = IDLE;
    endcase

    if (beat_fire) begin
      if (cnt_q == '0) begin
        state_d = IDLE;
`ifdef MEM_PORT_ARBITER_FIXED_PRIO_EN
        prio_d  = 1'b0;
`else
        prio_d  = ~owner_q;
`endif
      end else begin
        cnt_d = cnt_q - MEM_LEN_BITS'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//==============================================================================
// tb_mem_port_arbiter : randomized scoreboard bench for mem_port_arbiter.
// Revision            : 1.0
//==============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  typedef struct packed {
    logic        cl;
    logic        op;
    logic [7:0]  len;
    logic [63:0] addr;
  } txn_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        crv [2];
  logic        cro [2];
  logic [7:0]  crl [2];
  logic [63:0] cra [2];
  logic        cwv [2];
  logic [63:0] cwb [2];
  logic        crr [2];

  logic        c0_req_ready, c1_req_ready, c0_rd_valid, c1_rd_valid;
  logic [63:0] c0_rd_bits, c1_rd_bits;
  logic        mem_req_valid, mem_req_opcode, mem_wr_valid, mem_rd_ready, busy;
  logic [7:0]  mem_req_len;
  logic [63:0] mem_req_addr, mem_wr_bits;
  logic        mem_rd_valid;
  logic [63:0] mem_rd_bits;

  logic        rdy [2];
  logic        rdv [2];
  logic [63:0] rdb [2];
  assign rdy[0] = c0_req_ready;
  assign rdy[1] = c1_req_ready;
  assign rdv[0] = c0_rd_valid;
  assign rdv[1] = c1_rd_valid;
  assign rdb[0] = c0_rd_bits;
  assign rdb[1] = c1_rd_bits;

  mem_port_arbiter dut (
    .clock(clock), .reset(reset),
    .c0_req_valid(crv[0]), .c0_req_opcode(cro[0]), .c0_req_len(crl[0]), .c0_req_addr(cra[0]),
    .c0_req_ready(c0_req_ready), .c0_wr_valid(cwv[0]), .c0_wr_bits(cwb[0]),
    .c0_rd_valid(c0_rd_valid), .c0_rd_bits(c0_rd_bits), .c0_rd_ready(crr[0]),
    .c1_req_valid(crv[1]), .c1_req_opcode(cro[1]), .c1_req_len(crl[1]), .c1_req_addr(cra[1]),
    .c1_req_ready(c1_req_ready), .c1_wr_valid(cwv[1]), .c1_wr_bits(cwb[1]),
    .c1_rd_valid(c1_rd_valid), .c1_rd_bits(c1_rd_bits), .c1_rd_ready(crr[1]),
    .mem_req_valid(mem_req_valid), .mem_req_opcode(mem_req_opcode),
    .mem_req_len(mem_req_len), .mem_req_addr(mem_req_addr),
    .mem_wr_valid(mem_wr_valid), .mem_wr_bits(mem_wr_bits),
    .mem_rd_valid(mem_rd_valid), .mem_rd_bits(mem_rd_bits),
    .mem_rd_ready(mem_rd_ready), .busy(busy)
  );

  int checks = 0;
  int passes = 0;

  txn_t        exp_req [$];
  logic [63:0] exp_rd0 [$];
  logic [63:0] exp_rd1 [$];
  logic [63:0] exp_wr  [$];
  bit          prio_m;

  function automatic logic [63:0] rdata(input logic [63:0] a, input int i);
    return (a * 64'h0000_0001_0000_0193) ^ 64'(i) ^ 64'hA000_0000_0000_000A;
  endfunction

  function automatic logic [63:0] wdata(input int c, input logic [63:0] a, input int i);
    return {a[31:0], 32'(i)} ^ ((c == 1) ? 64'hC1C1_0000_0000_0000 : 64'hC0C0_0000_0000_0000);
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exv);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exv, $time);
  endtask

  // Reference model: whole transactions in arbitration order, priority flips after each.
  task automatic push_txn(input txn_t t);
    exp_req.push_back(t);
    for (int i = 0; i <= int'(t.len); i++) begin
      if (t.op == 1'b0) begin
        if (t.cl) exp_rd1.push_back(rdata(t.addr, i));
        else      exp_rd0.push_back(rdata(t.addr, i));
      end else begin
        exp_wr.push_back(wdata(int'(t.cl), t.addr, i));
      end
    end
`ifdef MEM_PORT_ARBITER_FIXED_PRIO_EN
    prio_m = 1'b0;
`else
    prio_m = ~t.cl;
`endif
  endtask

  // Write-beat hand-off from client threads to the write driver.
  int          wr_arm      [2];
  logic [7:0]  wr_len_pend [2];
  logic [63:0] wr_addr_pend[2];

  task automatic client(input int c, input txn_t t);
    bit got;
    @(posedge clock); #1;
    crv[c] = 1'b1; cro[c] = t.op; crl[c] = t.len; cra[c] = t.addr;
    got = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      if (rdy[c]) begin got = 1'b1; break; end
    end
    if (!got) chk(1'b0, "grant_timeout", 128'(c), 128'(c));
    else if (t.op) begin
      wr_len_pend[c]  = t.len;
      wr_addr_pend[c] = t.addr;
      wr_arm[c]       = wr_arm[c] + 1;
    end
    @(posedge clock); #1;
    crv[c] = 1'b0;
    cra[c] = {$urandom, $urandom};
    crl[c] = 8'($urandom);
  endtask

  task automatic flush();
    exp_req.delete(); exp_rd0.delete(); exp_rd1.delete(); exp_wr.delete();
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clock);
      if (exp_req.size() == 0 && exp_rd0.size() == 0 && exp_rd1.size() == 0 &&
          exp_wr.size() == 0 && !busy_exp) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      chk(1'b0, "round_timeout", 128'(exp_req.size()), 128'd0);
      flush();
    end
  endtask

  task automatic do_round(input txn_t t0, input txn_t t1, input bit use0, input bit use1);
    bit f;
    t0.cl = 1'b0;
    t1.cl = 1'b1;
    if (use0 && use1) begin
`ifdef MEM_PORT_ARBITER_FIXED_PRIO_EN
      f = 1'b0;
`else
      f = prio_m;
`endif
      if (f) begin push_txn(t1); push_txn(t0); end
      else   begin push_txn(t0); push_txn(t1); end
    end else if (use1) push_txn(t1);
    else               push_txn(t0);
    fork
      begin if (use0) client(0, t0); end
      begin if (use1) client(1, t1); end
    join
    wait_idle();
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.cl   = 1'b0;
    t.op   = 1'($urandom);
    t.len  = ($urandom % 12 == 0) ? 8'd255 : 8'($urandom % 6);
    t.addr = {$urandom, $urandom};
    return t;
  endfunction

  // Memory model: returns read beats for each accepted read, garbage otherwise.
  logic [63:0] pend [$];
  initial begin
    bit          fire, rq;
    logic [63:0] ra;
    logic [7:0]  rl;
    mem_rd_valid = 1'b0;
    mem_rd_bits  = '0;
    forever begin
      @(negedge clock);
      fire = mem_rd_valid && mem_rd_ready;
      rq   = mem_req_valid && (mem_req_opcode == 1'b0);
      ra   = mem_req_addr;
      rl   = mem_req_len;
      @(posedge clock); #1;
      if (!reset) pend.delete();
      else begin
        if (fire && pend.size() > 0) void'(pend.pop_front());
        if (rq) for (int i = 0; i <= int'(rl); i++) pend.push_back(rdata(ra, i));
      end
      if (pend.size() > 0) begin
        mem_rd_valid = ($urandom % 4 != 0);
        mem_rd_bits  = pend[0];
      end else begin
        mem_rd_valid = ($urandom % 3 == 0);
        mem_rd_bits  = 64'hDEAD_0000_0000_0000 | 64'($urandom);
      end
    end
  end

  // Write driver: owner beats with gaps, spurious garbage when not writing.
  initial begin
    int          wr_left [2];
    int          wr_idx  [2];
    int          wr_seen [2];
    logic [63:0] wr_base [2];
    bit          wfire   [2];
    for (int c = 0; c < 2; c++) begin
      wr_left[c] = 0; wr_idx[c] = 0; wr_seen[c] = 0; wr_base[c] = '0;
      cwv[c] = 1'b0; cwb[c] = '0;
    end
    forever begin
      @(negedge clock);
      for (int c = 0; c < 2; c++) wfire[c] = cwv[c] && (wr_left[c] > 0);
      @(posedge clock); #1;
      for (int c = 0; c < 2; c++) begin
        if (!reset) wr_left[c] = 0;
        else if (wr_arm[c] != wr_seen[c]) begin
          wr_seen[c] = wr_arm[c];
          wr_left[c] = int'(wr_len_pend[c]) + 1;
          wr_idx[c]  = 0;
          wr_base[c] = wr_addr_pend[c];
        end else if (wfire[c]) begin
          wr_idx[c]++;
          wr_left[c]--;
        end
        if (wr_left[c] > 0) begin
          cwv[c] = ($urandom % 3 != 0);
          cwb[c] = wdata(c, wr_base[c], wr_idx[c]);
        end else begin
          cwv[c] = ($urandom % 4 == 0);
          cwb[c] = 64'hBAD0_0000_0000_0000 | 64'($urandom);
        end
      end
    end
  end

  initial begin
    crr[0] = 1'b0; crr[1] = 1'b0;
    forever begin
      @(posedge clock); #1;
      crr[0] = ($urandom % 10 < 7);
      crr[1] = ($urandom % 10 < 7);
    end
  end

  // Monitor: every negedge compares routing/grants against the model and pops beats.
  bit   busy_exp;
  int   cur_left;
  logic cur_cl, cur_op;
  initial begin
    bit   rd_act, wr_act, beat;
    bit   ev;
    txn_t t;
    logic [63:0] e;
    busy_exp = 1'b0; cur_left = 0; cur_cl = 1'b0; cur_op = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        busy_exp = 1'b0;
        cur_left = 0;
      end else begin
        rd_act = busy_exp && (cur_op == 1'b0);
        wr_act = busy_exp && (cur_op == 1'b1);
        beat   = 1'b0;
        chk(busy == busy_exp, "busy", 128'(busy), 128'(busy_exp));
        for (int c = 0; c < 2; c++) begin
          ev = rd_act && (cur_cl == 1'(c));
          chk({rdv[c], rdb[c]} == (ev ? {mem_rd_valid, mem_rd_bits} : 65'd0), "rd_route",
              128'({rdv[c], rdb[c]}), 128'(ev ? {mem_rd_valid, mem_rd_bits} : 65'd0));
        end
        chk(mem_rd_ready == (rd_act ? crr[cur_cl] : 1'b0), "mem_rd_ready",
            128'(mem_rd_ready), 128'(rd_act ? crr[cur_cl] : 1'b0));
        chk({mem_wr_valid, mem_wr_bits} == (wr_act ? {cwv[cur_cl], cwb[cur_cl]} : 65'd0), "wr_route",
            128'({mem_wr_valid, mem_wr_bits}), 128'(wr_act ? {cwv[cur_cl], cwb[cur_cl]} : 65'd0));
        if (busy_exp) begin
          chk(!(mem_req_valid || rdy[0] || rdy[1]), "grant_while_busy",
              128'({mem_req_valid, rdy[0], rdy[1]}), 128'd0);
        end else if (mem_req_valid) begin
          if (exp_req.size() == 0) chk(1'b0, "unexpected_req", 128'(mem_req_addr), 128'd0);
          else begin
            t = exp_req.pop_front();
            chk({rdy[1], rdy[0]} == {t.cl, ~t.cl}, "req_client",
                128'({rdy[1], rdy[0]}), 128'({t.cl, ~t.cl}));
            chk({mem_req_opcode, mem_req_len, mem_req_addr} == {t.op, t.len, t.addr}, "req_fields",
                128'({mem_req_opcode, mem_req_len, mem_req_addr}), 128'({t.op, t.len, t.addr}));
            cur_cl = t.cl; cur_op = t.op; cur_left = int'(t.len) + 1; busy_exp = 1'b1;
          end
        end else begin
          chk(!rdy[0] && !rdy[1], "ready_without_req", 128'({rdy[0], rdy[1]}), 128'd0);
        end
        if (rd_act && mem_rd_valid && mem_rd_ready) begin
          beat = 1'b1;
          if ((cur_cl ? exp_rd1.size() : exp_rd0.size()) == 0)
            chk(1'b0, "unexpected_rd_beat", 128'(mem_rd_bits), 128'd0);
          else begin
            e = cur_cl ? exp_rd1.pop_front() : exp_rd0.pop_front();
            chk(rdb[cur_cl] == e, "rd_data", 128'(rdb[cur_cl]), 128'(e));
          end
        end
        if (wr_act && mem_wr_valid) begin
          beat = 1'b1;
          if (exp_wr.size() == 0) chk(1'b0, "unexpected_wr_beat", 128'(mem_wr_bits), 128'd0);
          else begin
            e = exp_wr.pop_front();
            chk(mem_wr_bits == e, "wr_data", 128'(mem_wr_bits), 128'(e));
          end
        end
        if (beat) begin
          cur_left--;
          if (cur_left == 0) busy_exp = 1'b0;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got %0d expected 0 pending", exp_req.size());
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t a, b;
    bit   ok;
    for (int c = 0; c < 2; c++) begin
      crv[c] = 1'b0; cro[c] = 1'b0; crl[c] = '0; cra[c] = '0;
      wr_arm[c] = 0; wr_len_pend[c] = '0; wr_addr_pend[c] = '0;
    end
    prio_m = 1'b0;
    reset  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk({busy, mem_req_valid, mem_rd_ready, mem_wr_valid, c0_rd_valid, c1_rd_valid} == 6'd0,
        "reset_outputs", 128'({busy, mem_req_valid, mem_rd_ready, mem_wr_valid, c0_rd_valid, c1_rd_valid}), 128'd0);
    reset = 1'b1;

    a = '{cl: 1'b0, op: 1'b0, len: 8'd3, addr: 64'h1000};
    do_round(a, a, 1'b1, 1'b0);
    a = '{cl: 1'b0, op: 1'b0, len: 8'd1, addr: 64'h2000};
    b = '{cl: 1'b1, op: 1'b1, len: 8'd0, addr: 64'h3000};
    do_round(a, b, 1'b1, 1'b1);
    do_round(a, b, 1'b1, 1'b1);
    a = '{cl: 1'b0, op: 1'b1, len: 8'd0, addr: 64'h4000};
    do_round(a, a, 1'b1, 1'b0);
    a = '{cl: 1'b0, op: 1'b0, len: 8'd255, addr: 64'h5000};
    do_round(a, a, 1'b1, 1'b0);

    for (int r = 0; r < 50; r++) begin
      int mode = int'($urandom % 4);
      a = rand_txn();
      b = rand_txn();
      do_round(a, b, mode != 1, mode != 0);
    end

    // Reset in the middle of a 4-beat read.
    a = '{cl: 1'b0, op: 1'b0, len: 8'd3, addr: 64'h6000};
    push_txn(a);
    client(0, a);
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clock);
      if (exp_rd0.size() <= 2) begin ok = 1'b1; break; end
    end
    chk(ok, "reset_wait_two_beats", 128'(exp_rd0.size()), 128'd2);
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    chk({busy, mem_req_valid, mem_rd_ready, mem_wr_valid, c0_req_ready, c1_req_ready, c0_rd_valid, c1_rd_valid} == 8'd0 &&
        (mem_req_addr | c0_rd_bits | c1_rd_bits | mem_wr_bits) == 64'd0 && mem_req_len == 8'd0,
        "async_reset_outputs",
        128'({busy, mem_req_valid, mem_rd_ready, mem_wr_valid, c0_req_ready, c1_req_ready, c0_rd_valid, c1_rd_valid}), 128'd0);
    flush();
    prio_m = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    a = rand_txn();
    b = rand_txn();
    do_round(a, b, 1'b1, 1'b1);
    for (int r = 0; r < 10; r++) begin
      a = rand_txn();
      b = rand_txn();
      do_round(a, b, 1'b1, 1'b1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
